// File: rtl/aurora_tx_framer.sv
// Multi-channel Aurora LocalLink transmit framer: round-robin over NCH FWFT FIFOs,
// wraps each burst in an SOF header and an EOF trailer carrying the word count.
`timescale 1ns/1ps
module aurora_tx_framer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NCH     = 4,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   fifo_data_i,
    input  logic [NCH-1:0]         fifo_empty_i,
    output logic [NCH-1:0]         fifo_read_o,
    output logic [WIDTH-1:0]       tx_d,
    output logic                   tx_src_rdy_n,
    output logic                   tx_sof_n,
    output logic                   tx_eof_n,
    input  logic                   tx_dst_rdy_n,
    input  logic                   link_active,
    output logic [31:0]            frame_count_o,
    output logic [15:0]            drop_count_o
);

    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned LW = 8;

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_TRAILER} state_t;

    state_t            state, state_d;
    logic [CW-1:0]     grant, grant_d;
    logic [CW-1:0]     last_grant, last_grant_d;
    logic [LW-1:0]     cnt, cnt_d;
    logic [WIDTH-1:0]  tx_d_d;
    logic              src_rdy_n_d, sof_n_d, eof_n_d;
    logic [31:0]       frame_count_d;
    logic [15:0]       drop_count_d;
    logic [NCH-1:0]    rd_c;
    logic              adv;
    logic              req_found;
    logic [CW-1:0]     req_idx;
    logic [CW-1:0]     cand;
    logic [WIDTH-1:0]  gnt_data;
    logic              gnt_empty;

    // Header/trailer layout: tag in the top byte, channel in [15:8], count in [7:0].
    function automatic logic [WIDTH-1:0] make_word(input logic [7:0] tag,
                                                   input logic [CW-1:0] ch,
                                                   input logic [LW-1:0] n);
        logic [WIDTH-1:0] w;
        w              = '0;
        w[WIDTH-1 -: 8] = tag;
        w[15:8]        = 8'(ch);
        w[7:0]         = n;
        return w;
    endfunction

    assign adv = link_active & (tx_src_rdy_n | ~tx_dst_rdy_n);

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            cand = CW'((32'(last_grant) + i) % NCH);
            if (!req_found && !fifo_empty_i[cand]) begin
                req_found = 1'b1;
                req_idx   = cand;
            end
        end
    end

    // Head word and empty flag of the granted channel.
    always_comb begin
        gnt_data  = '0;
        gnt_empty = 1'b1;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (grant == CW'(k)) begin
                gnt_data  = fifo_data_i[k*WIDTH +: WIDTH];
                gnt_empty = fifo_empty_i[k];
            end
        end
    end

    always_comb begin
        state_d       = state;
        grant_d       = grant;
        last_grant_d  = last_grant;
        cnt_d         = cnt;
        tx_d_d        = tx_d;
        src_rdy_n_d   = tx_src_rdy_n;
        sof_n_d       = tx_sof_n;
        eof_n_d       = tx_eof_n;
        frame_count_d = frame_count_o;
        drop_count_d  = drop_count_o;
        rd_c          = '0;

        if (!link_active) begin
            // Link loss abandons any frame in flight; the arbiter pointer is kept.
            state_d     = S_IDLE;
            src_rdy_n_d = 1'b1;
            sof_n_d     = 1'b1;
            eof_n_d     = 1'b1;
            if (state != S_IDLE && drop_count_o != 16'hFFFF)
                drop_count_d = drop_count_o + 16'd1;
        end else if (adv) begin
            case (state)
                S_IDLE: begin
                    if (req_found) begin
                        grant_d      = req_idx;
                        last_grant_d = req_idx;
                        cnt_d        = '0;
                        tx_d_d       = make_word(8'hA5, req_idx, 8'h00);
                        src_rdy_n_d  = 1'b0;
                        sof_n_d      = 1'b0;
                        eof_n_d      = 1'b1;
                        state_d      = S_PAYLOAD;
                    end else begin
                        src_rdy_n_d = 1'b1;
                        sof_n_d     = 1'b1;
                        eof_n_d     = 1'b1;
                    end
                end
                S_PAYLOAD: begin
                    src_rdy_n_d = 1'b0;
                    sof_n_d     = 1'b1;
                    if (!gnt_empty && cnt < LW'(MAX_LEN)) begin
                        rd_c[grant] = 1'b1;
                        tx_d_d      = gnt_data;
                        cnt_d       = cnt + 8'd1;
                        eof_n_d     = 1'b1;
                    end else begin
                        tx_d_d  = make_word(8'h5A, grant, cnt);
                        eof_n_d = 1'b0;
                        state_d = S_TRAILER;
                    end
                end
                S_TRAILER: begin
                    frame_count_d = frame_count_o + 32'd1;
                    src_rdy_n_d   = 1'b1;
                    sof_n_d       = 1'b1;
                    eof_n_d       = 1'b1;
                    state_d       = S_IDLE;
                end
                default: begin
                    state_d     = S_IDLE;
                    src_rdy_n_d = 1'b1;
                    sof_n_d     = 1'b1;
                    eof_n_d     = 1'b1;
                end
            endcase
        end
    end

    assign fifo_read_o = rd_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            grant         <= '0;
            last_grant    <= CW'(NCH - 1);
            cnt           <= '0;
            tx_d          <= '0;
            tx_src_rdy_n  <= 1'b1;
            tx_sof_n      <= 1'b1;
            tx_eof_n      <= 1'b1;
            frame_count_o <= '0;
            drop_count_o  <= '0;
        end else begin
            state         <= state_d;
            grant         <= grant_d;
            last_grant    <= last_grant_d;
            cnt           <= cnt_d;
            tx_d          <= tx_d_d;
            tx_src_rdy_n  <= src_rdy_n_d;
            tx_sof_n      <= sof_n_d;
            tx_eof_n      <= eof_n_d;
            frame_count_o <= frame_count_d;
            drop_count_o  <= drop_count_d;
        end
    end

endmodule

// File: tb/tb_aurora_tx_framer.sv
// Scoreboard bench for aurora_tx_framer: FWFT FIFO models feed the DUT, a monitor
// pops expected LocalLink words whenever a transfer occurs.
`timescale 1ns/1ps
module tb_aurora_tx_framer;

    localparam int unsigned W   = 32;
    localparam int unsigned NCH = 4;
    localparam int unsigned ML  = 16;

    typedef struct packed {
        logic [31:0] d;
        logic        sof;
        logic        eof;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [NCH*W-1:0]   fifo_data_i;
    logic [NCH-1:0]     fifo_empty_i;
    logic [NCH-1:0]     fifo_read_o;
    logic [W-1:0]       tx_d;
    logic               tx_src_rdy_n, tx_sof_n, tx_eof_n;
    logic               tx_dst_rdy_n;
    logic               link_active;
    logic [31:0]        frame_count_o;
    logic [15:0]        drop_count_o;

    exp_t               sb_q [$];
    logic [31:0]        fq [NCH][$];
    int unsigned        pop_cnt [NCH];
    int                 n_cmp = 0;
    int                 n_fail = 0;
    int unsigned        cyc = 0;
    int unsigned        last_eof_cyc = 0;
    int unsigned        last_gap = 0;
    logic [NCH-1:0]     rd_snap = '0;

    aurora_tx_framer #(.WIDTH(W), .NCH(NCH), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst),
        .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i), .fifo_read_o(fifo_read_o),
        .tx_d(tx_d), .tx_src_rdy_n(tx_src_rdy_n), .tx_sof_n(tx_sof_n), .tx_eof_n(tx_eof_n),
        .tx_dst_rdy_n(tx_dst_rdy_n), .link_active(link_active),
        .frame_count_o(frame_count_o), .drop_count_o(drop_count_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        for (int k = 0; k < NCH; k++) begin
            fifo_empty_i[k]       = (fq[k].size() == 0);
            fifo_data_i[k*W +: W] = (fq[k].size() == 0) ? 32'h0 : fq[k][0];
        end
    endtask

    task automatic load(input int ch, input logic [31:0] d);
        fq[ch].push_back(d);
        refresh();
    endtask

    function automatic logic [31:0] hdr(input int ch);
        return {8'hA5, 8'h00, 8'(ch), 8'h00};
    endfunction

    function automatic logic [31:0] trl(input int ch, input int n);
        return {8'h5A, 8'h00, 8'(ch), 8'(n)};
    endfunction

    task automatic exp_w(input logic [31:0] d, input logic sof, input logic eof);
        exp_t e;
        e.d = d;
        e.sof = sof;
        e.eof = eof;
        sb_q.push_back(e);
    endtask

    task automatic wait_frames(input int unsigned n, input string name);
        int unsigned t = 0;
        while (frame_count_o != n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check(name, 64'(frame_count_o), 64'(n));
    endtask

    task automatic drain(input string name);
        int unsigned t = 0;
        while (sb_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check(name, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic wait_word(input logic [31:0] d, input string name);
        int unsigned t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(tx_src_rdy_n == 1'b0 && tx_d == d) && t < 200);
        check(name, {31'h0, tx_src_rdy_n, tx_d}, {31'h0, 1'b0, d});
    endtask

    // Monitor: a transfer happens on the coming edge when valid, ready and link are up.
    initial forever begin
        @(negedge clk);
        #1;
        if (rst === 1'b0 && link_active && !tx_src_rdy_n && !tx_dst_rdy_n) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%0h sof_n=%0b eof_n=%0b, expected no transfer",
                         tx_d, tx_sof_n, tx_eof_n);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("bus_word", {30'h0, tx_d, ~tx_sof_n, ~tx_eof_n}, {30'h0, e.d, e.sof, e.eof});
            end
            if (!tx_sof_n) last_gap = cyc - last_eof_cyc;
            if (!tx_eof_n) last_eof_cyc = cyc;
        end
    end

    // FIFO model: pop requests are sampled mid-cycle and applied just after the edge.
    initial forever begin
        @(negedge clk);
        #1;
        rd_snap = fifo_read_o;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rst === 1'b0) begin
            for (int k = 0; k < NCH; k++) begin
                if (rd_snap[k]) begin
                    if (fq[k].size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL pop_empty: got pop on channel %0d, expected no pop of an empty FIFO", k);
                    end else begin
                        void'(fq[k].pop_front());
                        pop_cnt[k]++;
                    end
                end
            end
            refresh();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        link_active  = 1'b1;
        tx_dst_rdy_n = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            fq[k].delete();
            pop_cnt[k] = 0;
        end
        refresh();
        repeat (3) @(negedge clk);

        // Reset values
        check("reset_outputs", {27'h0, tx_d, tx_src_rdy_n, tx_sof_n, tx_eof_n, fifo_read_o},
              {27'h0, 32'h0, 1'b1, 1'b1, 1'b1, 4'h0});
        check("reset_counts", {16'h0, frame_count_o, drop_count_o}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single frame on channel 2
        exp_w(32'hA5000200, 1'b1, 1'b0);
        exp_w(32'h11, 1'b0, 1'b0);
        exp_w(32'h22, 1'b0, 1'b0);
        exp_w(32'h33, 1'b0, 1'b0);
        exp_w(32'h5A000203, 1'b0, 1'b1);
        load(2, 32'h11);
        load(2, 32'h22);
        load(2, 32'h33);
        wait_frames(1, "single_frame_count");
        drain("single_drain");
        check("single_pops_ch2", 64'(pop_cnt[2]), 64'd3);

        // Length cap: 20 words on channel 0 split 16 + 4
        exp_w(hdr(0), 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) exp_w(32'h100 + 32'(i), 1'b0, 1'b0);
        exp_w(32'h5A000010, 1'b0, 1'b1);
        exp_w(hdr(0), 1'b1, 1'b0);
        for (int i = 16; i < 20; i++) exp_w(32'h100 + 32'(i), 1'b0, 1'b0);
        exp_w(32'h5A000004, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) load(0, 32'h100 + 32'(i));
        wait_frames(3, "cap_frame_count");
        drain("cap_drain");
        check("cap_bubble_gap", 64'(last_gap), 64'd2);
        check("cap_pops_ch0", 64'(pop_cnt[0]), 64'd20);

        // Backpressure on the 2nd payload word of a channel 1 frame
        exp_w(hdr(1), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) exp_w(32'hB0 + 32'(i), 1'b0, 1'b0);
        exp_w(trl(1, 4), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) load(1, 32'hB0 + 32'(i));
        wait_word(32'hB1, "bp_reach_word");
        tx_dst_rdy_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_hold", {31'h0, tx_src_rdy_n, tx_d}, {31'h0, 1'b0, 32'hB1});
            check("bp_no_pop", 64'(fifo_read_o), 64'h0);
            @(negedge clk);
        end
        tx_dst_rdy_n = 1'b0;
        wait_frames(4, "bp_frame_count");
        drain("bp_drain");

        // Link drop during a channel 1 frame; the word popped just before the drop is lost
        exp_w(hdr(1), 1'b1, 1'b0);
        exp_w(32'hE0, 1'b0, 1'b0);
        exp_w(32'hE1, 1'b0, 1'b0);
        exp_w(hdr(1), 1'b1, 1'b0);
        for (int i = 3; i < 6; i++) exp_w(32'hE0 + 32'(i), 1'b0, 1'b0);
        exp_w(trl(1, 3), 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) load(1, 32'hE0 + 32'(i));
        wait_word(32'hE1, "drop_reach_word");
        @(negedge clk);
        link_active = 1'b0;
        @(negedge clk);
        #1;
        check("drop_valid_clear", 64'(tx_src_rdy_n), 64'd1);
        check("drop_count", 64'(drop_count_o), 64'd1);
        check("drop_no_pop", 64'(fifo_read_o), 64'h0);
        @(negedge clk);
        @(negedge clk);
        link_active = 1'b1;
        wait_frames(5, "drop_frame_count");
        drain("drop_drain");
        check("drop_pops_ch1", 64'(pop_cnt[1]), 64'd10);
        check("drop_count_hold", 64'(drop_count_o), 64'd1);

        // Async reset in the middle of a channel 3 payload
        exp_w(hdr(3), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) exp_w(32'h300 + 32'(i), 1'b0, 1'b0);
        exp_w(trl(3, 8), 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) load(3, 32'h300 + 32'(i));
        wait_word(32'h302, "areset_reach_word");
        #2;
        rst = 1'b1;
        #1;
        check("areset_outputs", {27'h0, tx_d, tx_src_rdy_n, tx_sof_n, tx_eof_n, fifo_read_o},
              {27'h0, 32'h0, 1'b1, 1'b1, 1'b1, 4'h0});
        check("areset_counts", {16'h0, frame_count_o, drop_count_o}, 64'h0);
        sb_q.delete();
        for (int k = 0; k < NCH; k++) fq[k].delete();
        refresh();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Round robin after reset: channel 0 first, then in order
        for (int k = 0; k < NCH; k++) begin
            exp_w(hdr(k), 1'b1, 1'b0);
            exp_w(32'hC0 + 32'(k), 1'b0, 1'b0);
            exp_w(trl(k, 1), 1'b0, 1'b1);
        end
        for (int k = 0; k < NCH; k++) load(k, 32'hC0 + 32'(k));
        wait_frames(4, "rr_frame_count");
        drain("rr_drain");

        exp_w(hdr(0), 1'b1, 1'b0);
        exp_w(32'hD0, 1'b0, 1'b0);
        exp_w(trl(0, 1), 1'b0, 1'b1);
        exp_w(hdr(3), 1'b1, 1'b0);
        exp_w(32'hD3, 1'b0, 1'b0);
        exp_w(trl(3, 1), 1'b0, 1'b1);
        load(3, 32'hD3);
        load(0, 32'hD0);
        wait_frames(6, "rr_refill_frame_count");
        drain("rr_refill_drain");
        check("rr_idle_after", 64'(tx_src_rdy_n), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
